// File: rtl/arm_code_writer.sv
// ARM emit-stream writer: buffers translated words in a small FIFO and drains
// them into code memory at consecutive word addresses, with bounds checking.
module arm_code_writer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] limit_addr,
    input  logic [31:0]       arm_inst,
    input  logic              valid_write,
    output logic              full,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] next_addr,
    output logic [ADDR_W-1:0] word_count,
    output logic              overflow,
    output logic              bounds_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [31:0]       r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W:0]    r_count;

    logic [ADDR_W-1:0] r_memAddr;
    logic [31:0]       r_memWdata;
    logic [ADDR_W-1:0] r_nextAddr;
    logic [ADDR_W-1:0] r_wordCount;
    logic              r_overflow;
    logic              r_boundsErr;

    logic              w_full;
    logic              w_busy;
    logic              w_push;
    logic              w_pop;
    logic              w_startTake;
    logic              w_discard;
    logic              w_load;
    logic              w_advance;
    logic [ADDR_W-1:0] w_addrInc;
    logic [ADDR_W-1:0] w_loadAddr;
    logic [31:0]       w_loadData;
    logic [ADDR_W-1:0] w_baseAligned;

    assign w_full        = (r_count == (PTR_W+1)'(DEPTH));
    assign w_busy        = (r_count != '0) || (r_state == ST_WRITE);
    assign w_push        = valid_write && !w_full;
    assign w_startTake   = start && !w_busy;
    assign w_addrInc     = r_nextAddr + ADDR_W'(4);
    assign w_baseAligned = base_addr & ~ADDR_W'(3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Out-of-bounds words are popped and dropped from IDLE, one per cycle.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_discard   = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_loadAddr  = r_nextAddr;
        w_loadData  = r_fifo[r_rdPtr];
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    if (r_nextAddr >= limit_addr) begin
                        w_pop     = 1'b1;
                        w_discard = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_nextState = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    w_pop     = 1'b1;
                    w_advance = 1'b1;
                    if ((r_count > (PTR_W+1)'(1)) && (w_addrInc < limit_addr)) begin
                        w_load      = 1'b1;
                        w_loadAddr  = w_addrInc;
                        w_loadData  = r_fifo[r_rdPtr + PTR_W'(1)];
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= arm_inst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new block can only open while nothing is buffered or in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_nextAddr  <= '0;
            r_wordCount <= '0;
            r_overflow  <= 1'b0;
            r_boundsErr <= 1'b0;
        end else begin
            if (w_load) begin
                r_memAddr  <= w_loadAddr;
                r_memWdata <= w_loadData;
            end
            if (w_startTake) begin
                r_nextAddr  <= w_baseAligned;
                r_wordCount <= '0;
            end else if (w_advance) begin
                r_nextAddr  <= w_addrInc;
                r_wordCount <= r_wordCount + ADDR_W'(1);
            end
            if (w_startTake) begin
                r_overflow <= 1'b0;
            end else if (valid_write && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_startTake) begin
                r_boundsErr <= 1'b0;
            end else if (w_discard) begin
                r_boundsErr <= 1'b1;
            end
        end
    end

    assign full       = w_full;
    assign busy       = w_busy;
    assign mem_we     = (r_state == ST_WRITE);
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;
    assign next_addr  = r_nextAddr;
    assign word_count = r_wordCount;
    assign overflow   = r_overflow;
    assign bounds_err = r_boundsErr;

endmodule

// File: tb/tb_arm_code_writer.sv
// Scoreboard bench for arm_code_writer: a word-level model predicts every
// memory write and sticky flag; a negedge monitor checks what the DUT writes.
module tb_arm_code_writer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] baseAddr;
    logic [15:0] limitAddr;
    logic [31:0] armInst;
    logic        validWrite;
    logic        full;
    logic        busy;
    logic [15:0] memAddr;
    logic [31:0] memWdata;
    logic        memWe;
    logic        memAck;
    logic [15:0] nextAddr;
    logic [15:0] wordCount;
    logic        overflow;
    logic        boundsErr;

    arm_code_writer #(.DEPTH(4), .ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (baseAddr),
        .limit_addr (limitAddr),
        .arm_inst   (armInst),
        .valid_write(validWrite),
        .full       (full),
        .busy       (busy),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_we     (memWe),
        .mem_ack    (memAck),
        .next_addr  (nextAddr),
        .word_count (wordCount),
        .overflow   (overflow),
        .bounds_err (boundsErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int hsCount     = 0;

    // Word-level reference model: each accepted word either gets the next
    // address in the block or, if that address is at/after the limit, is dropped.
    logic [47:0] expQ[$];
    logic [15:0] modelAddr  = 16'h0000;
    logic [15:0] modelCount = 16'h0000;
    logic        expOvf     = 1'b0;
    logic        expBerr    = 1'b0;
    logic [47:0] front;

    function automatic void modelPush(input logic [31:0] data);
        if (modelAddr >= limitAddr) begin
            expBerr = 1'b1;
        end else begin
            expQ.push_back({modelAddr, data});
            modelAddr  = modelAddr + 16'd4;
            modelCount = modelCount + 16'd1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic st, input logic [15:0] base, input logic vw,
                                 input logic [31:0] data, input logic stTaken, input logic pushTaken);
        start      = st;
        baseAddr   = base;
        validWrite = vw;
        armInst    = data;
        if (st && stTaken) begin
            modelAddr  = base & 16'hFFFC;
            modelCount = 16'h0000;
            expOvf     = 1'b0;
            expBerr    = 1'b0;
        end
        if (vw) begin
            if (pushTaken) modelPush(data);
            else           expOvf = 1'b1;
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        validWrite = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while ((busy || expQ.size() != 0) && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: got busy=%0d pending=%0d, expected idle", tag, busy, expQ.size());
        end
    endtask

    task automatic checkBlock(input string tag);
        checkOutput({tag, "_next_addr"},  32'(nextAddr),  32'(modelAddr));
        checkOutput({tag, "_word_count"}, 32'(wordCount), 32'(modelCount));
        checkOutput({tag, "_overflow"},   32'(overflow),  32'(expOvf));
        checkOutput({tag, "_bounds_err"}, 32'(boundsErr), 32'(expBerr));
        checkOutput({tag, "_busy"},       32'(busy),      32'd0);
        checkOutput({tag, "_mem_we"},     32'(memWe),     32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_full"},       32'(full),      32'd0);
        checkOutput({tag, "_busy"},       32'(busy),      32'd0);
        checkOutput({tag, "_mem_we"},     32'(memWe),     32'd0);
        checkOutput({tag, "_mem_addr"},   32'(memAddr),   32'd0);
        checkOutput({tag, "_mem_wdata"},  memWdata,       32'd0);
        checkOutput({tag, "_next_addr"},  32'(nextAddr),  32'd0);
        checkOutput({tag, "_word_count"}, 32'(wordCount), 32'd0);
        checkOutput({tag, "_overflow"},   32'(overflow),  32'd0);
        checkOutput({tag, "_bounds_err"}, 32'(boundsErr), 32'd0);
    endtask

    // Monitor: any presented write must match the head of the expected queue;
    // the entry retires when the memory acknowledges it.
    always @(negedge clk) begin
        if (!reset && memWe) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", memAddr, memWdata);
            end else begin
                front = expQ[0];
                if ({memAddr, memWdata} !== front) begin
                    miscompares++;
                    $display("[TB] FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             memAddr, memWdata, front[47:32], front[31:0]);
                end
                if (memAck) begin
                    void'(expQ.pop_front());
                    hsCount++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hsMark;
        reset      = 1'b1;
        start      = 1'b0;
        baseAddr   = '0;
        limitAddr  = '0;
        armInst    = '0;
        validWrite = 1'b0;
        memAck     = 1'b0;
        #3;
        checkResetValues("reset");
        tick(2);
        reset = 1'b0;
        tick(1);

        // Basic drain with one-cycle latency.
        limitAddr = 16'h1000;
        memAck    = 1'b1;
        applyStimulus(1'b1, 16'h0100, 1'b1, 32'hE3400005, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 32'hE52D0004, 1'b0, 1'b1);
        checkOutput("latency_mem_we",   32'(memWe),   32'd1);
        checkOutput("latency_mem_addr", 32'(memAddr), 32'h0100);
        waitIdle("basic");
        checkBlock("basic");

        // Backpressure: four words fill the FIFO, a fifth is dropped.
        memAck = 1'b0;
        hsMark = hsCount;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 32'hA0000000 + 32'(i), 1'b0, 1'b1);
        checkOutput("bp_full", 32'(full), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("bp_overflow", 32'(overflow), 32'd1);
        tick(3);
        memAck = 1'b1;
        waitIdle("bp");
        checkOutput("bp_writes", 32'(hsCount - hsMark), 32'd4);
        checkBlock("bp");

        // Bounds: third word lands on the limit and is discarded.
        applyStimulus(1'b1, 16'h0FF8, 1'b1, 32'h11111111, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0,    1'b1, 32'h22222222, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0,    1'b1, 32'h33333333, 1'b0, 1'b1);
        waitIdle("bounds");
        checkBlock("bounds");

        // start while busy is ignored; a later idle start takes effect with its push.
        memAck = 1'b0;
        applyStimulus(1'b1, 16'h0800, 1'b1, 32'h44440000, 1'b1, 1'b1);
        for (int i = 1; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 32'h44440000 + 32'(i), 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0200, 1'b1, 32'h55555555, 1'b0, 1'b0);
        checkOutput("busy_start_next_addr", 32'(nextAddr), 32'h0800);
        memAck = 1'b1;
        waitIdle("busy_start");
        checkBlock("busy_start");
        applyStimulus(1'b1, 16'h0200, 1'b1, 32'h66666666, 1'b1, 1'b1);
        waitIdle("idle_start");
        checkBlock("idle_start");

        // Asynchronous reset in the middle of a stalled write.
        memAck = 1'b0;
        applyStimulus(1'b1, 16'h0300, 1'b1, 32'h77770000, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0,    1'b1, 32'h77770001, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0,    1'b1, 32'h77770002, 1'b0, 1'b1);
        checkOutput("stall_mem_we", 32'(memWe), 32'd1);
        #1 reset = 1'b1;
        #1 checkResetValues("async_reset");
        #1 reset = 1'b0;
        expQ.delete();
        modelAddr  = 16'h0000;
        modelCount = 16'h0000;
        expOvf     = 1'b0;
        expBerr    = 1'b0;
        hsMark     = hsCount;
        memAck     = 1'b1;
        tick(5);
        checkOutput("post_reset_writes", 32'(hsCount - hsMark), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 32'h88888888, 1'b0, 1'b1);
        waitIdle("no_start");
        checkBlock("no_start");

        // Address wrap past the top of the 16-bit space.
        limitAddr = 16'hFFFF;
        applyStimulus(1'b1, 16'hFFFC, 1'b1, 32'h99990000, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0,    1'b1, 32'h99990001, 1'b0, 1'b1);
        waitIdle("wrap");
        checkBlock("wrap");

        // Randomized blocks with random limits, stalls and ignored starts.
        for (int r = 0; r < 20; r++) begin
            logic [15:0] base;
            base      = 16'($urandom);
            limitAddr = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                    : (base & 16'hFFFC) + 16'(4 * $urandom_range(0, 10));
            applyStimulus(1'b1, base, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b1);
            for (int c = 0; c < 40; c++) begin
                logic doPush;
                logic doStart;
                memAck  = ($urandom_range(0, 2) != 0);
                doPush  = ($urandom_range(0, 1) == 1) && !full;
                doStart = ($urandom_range(0, 15) == 0) && busy;
                applyStimulus(doStart, 16'($urandom), doPush, $urandom, 1'b0, 1'b1);
            end
            memAck = 1'b1;
            waitIdle("random");
            checkBlock("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
